// File: rtl/note_lane_renderer.sv
// One falling-note lane: four note slots plus a 3-stage sprite render pipeline.
// Optional macro NOTE_TRANSPARENCY_EN masks sprite pixels equal to KEY_RGB.
module note_lane_renderer #(
    parameter logic [9:0]  LANE_X    = 10'd0,
    parameter logic [3:0]  SPEED     = 4'd4,
    parameter logic [23:0] KEY_RGB   = 24'hFF00FF,
    parameter logic [9:0]  STRIKE_LO = 10'd384,
    parameter logic [9:0]  STRIKE_HI = 10'd416
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_tick,
    input  logic        spawn,
    input  logic        strike,
    output logic [12:0] rom_addr,
    input  logic [23:0] rom_data,
    output logic [23:0] pixel_rgb,
    output logic        pixel_valid,
    output logic        hit_ok,
    output logic        miss,
    output logic        spawn_drop
);

    function automatic logic [3:0] lowest_one(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    logic [3:0]  active;
    logic [9:0]  y [4];

    logic [3:0]  in_win;
    logic [3:0]  strike_sel;
    logic [3:0]  spawn_sel;
    logic [3:0]  exits;
    logic [10:0] sum [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_win[i] = active[i] && (y[i] >= STRIKE_LO) && (y[i] <= STRIKE_HI);
            sum[i]    = {1'b0, y[i]} + {7'd0, SPEED};
            exits[i]  = active[i] && (sum[i] >= 11'd480);
        end
        strike_sel = lowest_one(in_win);
        spawn_sel  = lowest_one(~active);
    end

    // All slot decisions are taken from the pre-edge state; a strike beats a tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            active     <= 4'd0;
            hit_ok     <= 1'b0;
            miss       <= 1'b0;
            spawn_drop <= 1'b0;
            for (int i = 0; i < 4; i++) y[i] <= 10'd0;
        end else begin
            hit_ok     <= strike && (|strike_sel);
            miss       <= frame_tick && (|(exits & ~(strike ? strike_sel : 4'd0)));
            spawn_drop <= spawn && (&active);
            for (int i = 0; i < 4; i++) begin
                if (strike && strike_sel[i]) begin
                    active[i] <= 1'b0;
                end else if (frame_tick && active[i]) begin
                    if (exits[i]) active[i] <= 1'b0;
                    else          y[i]      <= sum[i][9:0];
                end else if (spawn && spawn_sel[i]) begin
                    active[i] <= 1'b1;
                    y[i]      <= 10'd0;
                end
            end
        end
    end

    logic        in_x;
    logic        hit_any;
    logic [5:0]  y_hit;
    logic [5:0]  dx6;
    logic [5:0]  dy6;
    logic [12:0] addr_nxt;

    always_comb begin
        in_x    = ({1'b0, DrawX} >= {1'b0, LANE_X}) &&
                  ({1'b0, DrawX} <  ({1'b0, LANE_X} + 11'd64));
        hit_any = 1'b0;
        y_hit   = 6'd0;
        // Scan high to low so the lowest-index hitting slot is the one kept.
        for (int i = 3; i >= 0; i--) begin
            if (active[i] && in_x &&
                ({1'b0, DrawY} >= {1'b0, y[i]}) &&
                ({1'b0, DrawY} <  ({1'b0, y[i]} + 11'd64))) begin
                hit_any = 1'b1;
                y_hit   = y[i][5:0];
            end
        end
        dx6      = DrawX[5:0] - LANE_X[5:0];
        dy6      = DrawY[5:0] - y_hit;
        addr_nxt = hit_any ? {1'b0, dy6, dx6} : 13'd0;
    end

    logic [12:0] addr_p0;
    logic        vld_p0;
    logic        vld_p1;
    logic        vld_p2;
    logic [23:0] rgb_p2;
    logic        pix_vld;

`ifdef NOTE_TRANSPARENCY_EN
    assign pix_vld = vld_p1 && (rom_data != KEY_RGB);
`else
    logic unused_key;
    assign unused_key = ^KEY_RGB;
    assign pix_vld    = vld_p1;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_p0 <= 13'd0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            rgb_p2  <= 24'd0;
        end else begin
            // stage 1: sprite address and hit flag
            addr_p0 <= addr_nxt;
            vld_p0  <= hit_any;
            // stage 2: hit flag aligned with ROM read data
            vld_p1  <= vld_p0;
            // stage 3: registered pixel outputs
            vld_p2  <= pix_vld;
            rgb_p2  <= pix_vld ? rom_data : 24'd0;
        end
    end

    assign rom_addr    = addr_p0;
    assign pixel_valid = vld_p2;
    assign pixel_rgb   = rgb_p2;

endmodule
